// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch/load-store paths, the memory port and the arbiter.
// The arbiter takes the slave view; the core/memory environment takes the master view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        if_err;

   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_err;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        core_stall;
   logic        bus_err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata, core_stall, bus_err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata, core_stall, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes instruction-fetch and load/store accesses onto one memory port, with
// alignment checking, store lane formatting and a bounded wait for mem_ack.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_e;

   // The access is aborted in the cycle the wait count would reach TIMEOUT.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        if_ready_q, if_ready_d;
   logic        if_err_q, if_err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        d_ready_q, d_ready_d;
   logic        d_err_q, d_err_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        bus_err_q, bus_err_d;

   logic        d_legal;
   logic [3:0]  d_be;
   logic [31:0] d_wdata_rep;

   // Alignment check and lane formatting of the incoming data request.
   always_comb begin
      d_legal     = 1'b1;
      d_be        = 4'b1111;
      d_wdata_rep = bus.d_wdata;
      unique case (bus.d_size)
         2'b00: begin
            d_be        = 4'b0001 << bus.d_addr[1:0];
            d_wdata_rep = {4{bus.d_wdata[7:0]}};
         end
         2'b01: begin
            d_legal     = ~bus.d_addr[0];
            d_be        = 4'b0011 << {bus.d_addr[1], 1'b0};
            d_wdata_rep = {2{bus.d_wdata[15:0]}};
         end
         2'b10:   d_legal = (bus.d_addr[1:0] == 2'b00);
         default: d_legal = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      if_ready_d  = 1'b0;
      if_err_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_ready_d   = 1'b0;
      d_err_d     = 1'b0;
      d_rdata_d   = d_rdata_q;
      bus_err_d   = bus_err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.d_req) begin
               if (d_legal) begin
                  state_d     = DATA;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = {bus.d_addr[31:2], 2'b00};
                  mem_be_d    = d_be;
                  mem_wdata_d = d_wdata_rep;
                  wait_cnt_d  = '0;
               end else begin
                  state_d   = RESP;
                  d_ready_d = 1'b1;
                  d_err_d   = 1'b1;
                  d_rdata_d = '0;
               end
            end else if (bus.if_req) begin
               if (bus.if_addr[1:0] == 2'b00) begin
                  state_d     = FETCH;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = {bus.if_addr[31:2], 2'b00};
                  mem_be_d    = 4'b1111;
                  mem_wdata_d = '0;
                  wait_cnt_d  = '0;
               end else begin
                  state_d    = RESP;
                  if_ready_d = 1'b1;
                  if_err_d   = 1'b1;
                  if_rdata_d = '0;
               end
            end
         end
         FETCH, DATA: begin
            // An ack in the final wait cycle still wins over the timeout.
            if (bus.mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               if (state_q == FETCH) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end else begin
                  d_ready_d = 1'b1;
                  d_rdata_d = bus.mem_rdata;
               end
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               if (state_q == FETCH) begin
                  if_ready_d = 1'b1;
                  if_err_d   = 1'b1;
                  if_rdata_d = '0;
               end else begin
                  d_ready_d = 1'b1;
                  d_err_d   = 1'b1;
                  d_rdata_d = '0;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      if (!rst_n) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         if_ready_q  <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         d_ready_q   <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         if_ready_q  <= if_ready_d;
         if_err_q    <= if_err_d;
         if_rdata_q  <= if_rdata_d;
         d_ready_q   <= d_ready_d;
         d_err_q     <= d_err_d;
         d_rdata_q   <= d_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.if_ready   = if_ready_q;
   assign bus.if_err     = if_err_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_ready    = d_ready_q;
   assign bus.d_err      = d_err_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.bus_err    = bus_err_q;
   assign bus.core_stall = (bus.if_req | bus.d_req) & ~(if_ready_q | d_ready_q);
endmodule
